// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared types, pip patterns and face mapping for the dice roller
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    RESULT  = 2'd2
  } dice_state_t;

  // Bit order: 0=TL 1=TR 2=ML 3=C 4=MR 5=BL 6=BR
  localparam logic [6:0] PIPS_BLANK = 7'b0000000;
  localparam logic [6:0] PIPS_ONE   = 7'b0001000;
  localparam logic [6:0] PIPS_TWO   = 7'b1000001;
  localparam logic [6:0] PIPS_THREE = 7'b1001001;
  localparam logic [6:0] PIPS_FOUR  = 7'b1100011;
  localparam logic [6:0] PIPS_FIVE  = 7'b1101011;
  localparam logic [6:0] PIPS_SIX   = 7'b1110111;

  // Out-of-range generator values fold back onto 1 and 2 so a face is never 7.
  function automatic logic [2:0] map_face(input logic [2:0] v);
    logic [2:0] f;
    case (v)
      3'd6:    f = 3'd1;
      3'd7:    f = 3'd2;
      default: f = v + 3'd1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - two-flop synchronizer plus rising-edge pulse for the roll button
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - roll controller: timed animation, final face latch and pip decode
module dice_roller
  import dice_pkg::*;
#(
  parameter int ROLL_CYCLES = 50_000_000,
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_roll,
  input  logic [2:0] rnd_in,
  output logic [2:0] face,
  output logic [6:0] pips,
  output logic       rolling,
  output logic       done,
  output logic [7:0] roll_count
);

  localparam int CW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(ROLL_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  dice_state_t r_state;
  dice_state_t w_next_state;

  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_face;
  logic          r_rolling;
  logic          r_done;
  logic [7:0]    r_roll_count;

  logic w_press;
  logic w_cnt_last;
  logic w_tick_last;
  logic w_start;
  logic w_finish;
  logic w_tick_load;
  logic [6:0] w_pips;

  btn_edge_sync u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_roll),
    .pulse (w_press)
  );

  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_tick_last = (r_tick == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_press) w_next_state = ROLLING;
      ROLLING: if (w_cnt_last) w_next_state = RESULT;
      RESULT:  if (w_press) w_next_state = ROLLING;
      default: w_next_state = IDLE;
    endcase
  end

  // Presses only matter outside ROLLING, including the edge that ends a roll.
  always_comb begin
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_tick_load = 1'b0;
    case (r_state)
      IDLE, RESULT: w_start = w_press;
      ROLLING: begin
        w_finish    = w_cnt_last;
        w_tick_load = w_tick_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_tick       <= '0;
      r_face       <= 3'd0;
      r_rolling    <= 1'b0;
      r_done       <= 1'b0;
      r_roll_count <= 8'd0;
    end else begin
      r_rolling <= (w_next_state == ROLLING);
      r_done    <= w_finish;
      if (w_start) begin
        r_cnt  <= '0;
        r_tick <= '0;
      end else if (r_state == ROLLING) begin
        r_cnt  <= r_cnt + CW'(1);
        r_tick <= w_tick_last ? '0 : r_tick + TW'(1);
      end
      if (w_finish || w_tick_load) begin
        r_face <= map_face(rnd_in);
      end
      if (w_finish) begin
        r_roll_count <= r_roll_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_pips = PIPS_BLANK;
    case (r_face)
      3'd1:    w_pips = PIPS_ONE;
      3'd2:    w_pips = PIPS_TWO;
      3'd3:    w_pips = PIPS_THREE;
      3'd4:    w_pips = PIPS_FOUR;
      3'd5:    w_pips = PIPS_FIVE;
      3'd6:    w_pips = PIPS_SIX;
      default: w_pips = PIPS_BLANK;
    endcase
  end

  assign face       = r_face;
  assign pips       = w_pips;
  assign rolling    = r_rolling;
  assign done       = r_done;
  assign roll_count = r_roll_count;

endmodule
